// File: rtl/msx_audio_mixer_if.sv
// Sample-strobe and audio bus between the MSX sound sources and the mixer.
// The master drives the sources and the strobe; the slave returns the mixed sample.
interface msx_audio_mixer_if #(
  parameter int PSG_W  = 10,
  parameter int CART_W = 16
);
  logic                     ce_sample;
  logic [PSG_W-1:0]         psg_in;
  logic                     keybeep;
  logic                     cas_in;
  logic                     cas_motor;
  logic signed [CART_W-1:0] cart_in;
  logic [2:0]               vol_psg;
  logic [2:0]               vol_cart;
  logic                     mute;
  logic signed [15:0]       audio_out;
  logic                     audio_valid;
  logic                     clip;
  logic                     overrun;

  modport master (
    output ce_sample, psg_in, keybeep, cas_in, cas_motor, cart_in,
           vol_psg, vol_cart, mute,
    input  audio_out, audio_valid, clip, overrun
  );

  modport slave (
    input  ce_sample, psg_in, keybeep, cas_in, cas_motor, cart_in,
           vol_psg, vol_cart, mute,
    output audio_out, audio_valid, clip, overrun
  );
endinterface

// File: rtl/msx_audio_mixer.sv
// Time-multiplexed MSX audio mixer: snapshot, per-source gain, accumulate, saturate.
// Define MSX_AUDIO_DCF_EN to insert a one-pole DC-blocking filter before saturation.
module msx_audio_mixer #(
  parameter int PSG_W     = 10,
  parameter int CART_W    = 16,
  parameter int DCF_SHIFT = 10
) (
  input  logic               clk21m,
  input  logic               reset,
  msx_audio_mixer_if.slave   bus
);
  localparam int ACC_W = 20;

  typedef enum logic [2:0] {
    S_IDLE, S_PSG, S_BEEP, S_CAS, S_CART, S_DCF, S_SAT
  } state_t;

  state_t                   state;
  state_t                   state_nxt;

  logic [PSG_W-1:0]         psg_q;
  logic                     beep_q;
  logic                     cas_q;
  logic                     motor_q;
  logic signed [CART_W-1:0] cart_q;
  logic [2:0]               volp_q;
  logic [2:0]               volc_q;
  logic                     mute_q;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  src_s;
  logic [2:0]               vol_s;
  logic signed [ACC_W-1:0]  term_s;
  logic signed [ACC_W-1:0]  sat_in_s;
  logic signed [15:0]       sat_val_s;
  logic                     sat_clip_s;

`ifdef MSX_AUDIO_DCF_EN
  logic signed [ACC_W-1:0]  x_prev;
  logic signed [ACC_W-1:0]  y_prev;
  logic signed [ACC_W-1:0]  y_s;
`endif

  // (src * vol) >>> 2 with vol=4 as unity; the shift floors toward -inf
  function automatic logic signed [ACC_W-1:0] scale(input logic signed [ACC_W-1:0] src,
                                                    input logic [2:0] vol);
    logic signed [ACC_W+3:0] src_ext;
    logic signed [ACC_W+3:0] vol_ext;
    logic signed [ACC_W+3:0] prod;
    src_ext = (ACC_W+4)'(src);
    vol_ext = (ACC_W+4)'($signed({1'b0, vol}));
    prod    = src_ext * vol_ext;
    return ACC_W'(prod >>> 2);
  endfunction

  // Sequencer next state: one source per cycle, leave idle only on a strobe
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.ce_sample) state_nxt = S_PSG; else state_nxt = S_IDLE;
      S_PSG:   state_nxt = S_BEEP;
      S_BEEP:  state_nxt = S_CAS;
      S_CAS:   state_nxt = S_CART;
      S_CART:  state_nxt = S_DCF;
      S_DCF:   state_nxt = S_SAT;
      S_SAT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Select the source and gain contributing in the current state
  always_comb begin
    src_s = '0;
    vol_s = 3'd0;
    case (state)
      S_PSG:   begin src_s = ACC_W'({psg_q, 4'b0000}); vol_s = volp_q; end
      S_BEEP:  begin src_s = beep_q ? 20'sd512 : 20'sd0; vol_s = volp_q; end
      S_CAS:   begin src_s = (cas_q && !motor_q) ? 20'sd256 : 20'sd0; vol_s = volp_q; end
      S_CART:  begin src_s = ACC_W'(cart_q); vol_s = volc_q; end
      default: begin src_s = '0; vol_s = 3'd0; end
    endcase
    term_s = scale(src_s, vol_s);
  end

`ifdef MSX_AUDIO_DCF_EN
  // y[n] = x[n] - x[n-1] + y[n-1] - y[n-1]/2^k; y_prev holds y[n] by S_SAT
  always_comb begin
    y_s      = acc - x_prev + y_prev - (y_prev >>> DCF_SHIFT);
    sat_in_s = y_prev;
  end
`else
  // Without the filter the accumulator feeds saturation directly
  always_comb begin
    sat_in_s = acc;
  end
`endif

  // Clamp to signed 16-bit and flag when clamping happened
  always_comb begin
    if (sat_in_s > 20'sd32767) begin
      sat_val_s  = 16'sh7FFF;
      sat_clip_s = 1'b1;
    end else if (sat_in_s < -20'sd32768) begin
      sat_val_s  = 16'sh8000;
      sat_clip_s = 1'b1;
    end else begin
      sat_val_s  = 16'(sat_in_s);
      sat_clip_s = 1'b0;
    end
  end

  // State register, snapshot, accumulator, filter state and registered outputs
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      psg_q           <= '0;
      beep_q          <= 1'b0;
      cas_q           <= 1'b0;
      motor_q         <= 1'b0;
      cart_q          <= '0;
      volp_q          <= 3'd0;
      volc_q          <= 3'd0;
      mute_q          <= 1'b0;
      acc             <= '0;
`ifdef MSX_AUDIO_DCF_EN
      x_prev          <= '0;
      y_prev          <= '0;
`endif
      bus.audio_out   <= 16'sd0;
      bus.audio_valid <= 1'b0;
      bus.clip        <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.audio_valid <= 1'b0;
      bus.clip        <= 1'b0;
      if (bus.ce_sample && (state != S_IDLE)) bus.overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.ce_sample) begin
            psg_q   <= bus.psg_in;
            beep_q  <= bus.keybeep;
            cas_q   <= bus.cas_in;
            motor_q <= bus.cas_motor;
            cart_q  <= bus.cart_in;
            volp_q  <= bus.vol_psg;
            volc_q  <= bus.vol_cart;
            mute_q  <= bus.mute;
            acc     <= '0;
          end
        end
        S_PSG, S_BEEP, S_CAS, S_CART: acc <= acc + term_s;
`ifdef MSX_AUDIO_DCF_EN
        S_DCF: begin
          x_prev <= acc;
          y_prev <= y_s;
        end
`endif
        S_SAT: begin
          bus.audio_valid <= 1'b1;
          if (mute_q) begin
            bus.audio_out <= 16'sd0;
            bus.clip      <= 1'b0;
          end else begin
            bus.audio_out <= sat_val_s;
            bus.clip      <= sat_clip_s;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_msx_audio_mixer.sv
// Randomized and directed bench for msx_audio_mixer against an integer reference model.
// Follows MSX_AUDIO_DCF_EN so the model matches the compiled filter option.
module tb_msx_audio_mixer;
  logic clk21m = 1'b0;
  logic reset  = 1'b1;

  always #5 clk21m = ~clk21m;

  msx_audio_mixer_if #(.PSG_W(10), .CART_W(16)) bus ();

  msx_audio_mixer #(.PSG_W(10), .CART_W(16), .DCF_SHIFT(10)) dut (
    .clk21m (clk21m),
    .reset  (reset),
    .bus    (bus.slave)
  );

`ifdef MSX_AUDIO_DCF_EN
  localparam bit NO_DCF = 1'b0;
`else
  localparam bit NO_DCF = 1'b1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int m_xp     = 0;
  int m_yp     = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gain(input int s, input int v);
    return (s * v) >>> 2;
  endfunction

  function automatic int wrap20(input int v);
    int m;
    m = v % 1048576;
    if (m < 0) m += 1048576;
    if (m >= 524288) m -= 1048576;
    return m;
  endfunction

  // Reference: sum of scaled sources, optional DC filter, clamp, mute
  task automatic model(input int psg, input int kb, input int cas, input int mot,
                       input int cart, input int vp, input int vc, input int mu,
                       output int eo, output int ec);
    int sum, v;
    sum = gain(psg * 16, vp) + gain(kb ? 512 : 0, vp)
        + gain((cas && !mot) ? 256 : 0, vp) + gain(cart, vc);
    v = sum;
`ifdef MSX_AUDIO_DCF_EN
    v    = wrap20(sum - m_xp + m_yp - (m_yp >>> 10));
    m_xp = sum;
    m_yp = v;
`endif
    ec = 0;
    if (v > 32767)       begin v = 32767;  ec = 1; end
    else if (v < -32768) begin v = -32768; ec = 1; end
    eo = mu ? 0 : v;
    if (mu) ec = 0;
  endtask

  task automatic drive(input int psg, input int kb, input int cas, input int mot,
                       input int cart, input int vp, input int vc, input int mu);
    bus.psg_in    = 10'(psg);
    bus.keybeep   = 1'(kb);
    bus.cas_in    = 1'(cas);
    bus.cas_motor = 1'(mot);
    bus.cart_in   = 16'(cart);
    bus.vol_psg   = 3'(vp);
    bus.vol_cart  = 3'(vc);
    bus.mute      = 1'(mu);
  endtask

  // One strobed sample; inputs are scrambled right after acceptance
  task automatic run_sample(input string tag, input int psg, input int kb, input int cas,
                            input int mot, input int cart, input int vp, input int vc,
                            input int mu, input bit use_lit, input int lit_out,
                            input int lit_clip, output int got);
    int eo, ec;
    model(psg, kb, cas, mot, cart, vp, vc, mu, eo, ec);
    if (use_lit) begin eo = lit_out; ec = lit_clip; end
    @(posedge clk21m); #1;
    drive(psg, kb, cas, mot, cart, vp, vc, mu);
    bus.ce_sample = 1'b1;
    @(posedge clk21m); #1;
    bus.ce_sample = 1'b0;
    drive($urandom_range(0, 1023), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 65535) - 32768,
          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1));
    got = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk21m);
      if (i < 7) begin
        check_eq({tag, "_early_valid"}, int'(bus.audio_valid), 0);
      end else begin
        got = int'($signed(bus.audio_out));
        check_eq({tag, "_valid"}, int'(bus.audio_valid), 1);
        check_eq({tag, "_out"}, got, eo);
        check_eq({tag, "_clip"}, int'(bus.clip), ec);
      end
    end
  endtask

  initial begin
    int got, prev, eo1, ec1, eo2, ec2, pulses;
    bit seen;
    bus.ce_sample = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk21m);
    check_eq("rst_out", int'($signed(bus.audio_out)), 0);
    check_eq("rst_valid", int'(bus.audio_valid), 0);
    check_eq("rst_clip", int'(bus.clip), 0);
    check_eq("rst_overrun", int'(bus.overrun), 0);
    reset = 1'b0;

    run_sample("psg_unity", 256, 0, 0, 0, 0, 4, 4, 0, NO_DCF, 4096, 0, got);
    run_sample("beep_cas", 0, 1, 1, 0, 0, 4, 4, 0, NO_DCF, 768, 0, got);
    run_sample("cas_motor", 0, 1, 1, 1, 0, 4, 4, 0, NO_DCF, 512, 0, got);
    run_sample("vol_psg0", 0, 1, 1, 0, 0, 0, 4, 0, NO_DCF, 0, 0, got);
    run_sample("cart_v2", 0, 0, 0, 0, 1000, 4, 2, 0, NO_DCF, 500, 0, got);
    run_sample("cart_v4", 0, 0, 0, 0, 1000, 4, 4, 0, NO_DCF, 1000, 0, got);
    run_sample("cart_v7", 0, 0, 0, 0, 1000, 4, 7, 0, NO_DCF, 1750, 0, got);
    run_sample("cart_v0", 0, 0, 0, 0, 1000, 4, 0, 0, NO_DCF, 0, 0, got);
    run_sample("cart_min", 0, 0, 0, 0, -32768, 0, 4, 0, NO_DCF, -32768, 0, got);
    run_sample("sat_pos", 1023, 0, 0, 0, 32767, 4, 4, 0, NO_DCF, 32767, 1, got);
    run_sample("sat_mute", 1023, 0, 0, 0, 32767, 4, 4, 1, NO_DCF, 0, 0, got);

    for (int n = 0; n < 40; n++) begin
      run_sample("rand", $urandom_range(0, 1023), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 65535) - 32768, $urandom_range(0, 7),
                 $urandom_range(0, 7), ($urandom_range(0, 7) == 0) ? 1 : 0,
                 1'b0, 0, 0, got);
    end

    // Strobes at cycles 0, 3 and 8: the middle one is dropped and flagged
    drive(256, 0, 0, 0, 0, 4, 4, 0);
    model(256, 0, 0, 0, 0, 4, 4, 0, eo1, ec1);
    model(256, 0, 0, 0, 0, 4, 4, 0, eo2, ec2);
    pulses = 0;
    @(posedge clk21m); #1;
    for (int c = 0; c <= 20; c++) begin
      bus.ce_sample = (c == 0 || c == 3 || c == 8);
      @(negedge clk21m);
      if (bus.audio_valid) pulses++;
      if (c == 7 || c == 15) begin
        check_eq("ovr_valid", int'(bus.audio_valid), 1);
        check_eq("ovr_out", int'($signed(bus.audio_out)), (c == 7) ? eo1 : eo2);
      end
      if (c == 3) check_eq("ovr_before", int'(bus.overrun), 0);
      @(posedge clk21m); #1;
    end
    bus.ce_sample = 1'b0;
    check_eq("ovr_pulses", pulses, 2);
    check_eq("ovr_sticky", int'(bus.overrun), 1);

    // Reset four cycles into a sample aborts it without a valid pulse
    @(posedge clk21m); #1;
    drive(256, 1, 1, 0, 1000, 4, 4, 0);
    bus.ce_sample = 1'b1;
    @(posedge clk21m); #1;
    bus.ce_sample = 1'b0;
    repeat (3) @(posedge clk21m);
    #1 reset = 1'b1;
    m_xp = 0;
    m_yp = 0;
    @(negedge clk21m);
    check_eq("abort_out", int'($signed(bus.audio_out)), 0);
    check_eq("abort_overrun", int'(bus.overrun), 0);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk21m);
      if (bus.audio_valid || bus.audio_out != 16'sd0) seen = 1'b1;
    end
    check_eq("abort_quiet", int'(seen), 0);

`ifdef MSX_AUDIO_DCF_EN
    run_sample("dcf_first", 256, 0, 0, 0, 0, 4, 4, 0, 1'b1, 4096, 0, got);
    prev = got;
    for (int n = 0; n < 6; n++) begin
      run_sample("dcf_step", 256, 0, 0, 0, 0, 4, 4, 0, 1'b0, 0, 0, got);
      check_eq("dcf_decay", int'(got < prev && got >= 0), 1);
      prev = got;
    end
`else
    run_sample("post_abort", 256, 0, 0, 0, 0, 4, 4, 0, 1'b1, 4096, 0, got);
    prev = got;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
